// File: rtl/conv_pkg.sv
// Shared layer geometry and scheduler state encoding for the convolution
// window scheduler and its index counter.
package conv_pkg;

   localparam int IMG_W    = 32;
   localparam int K        = 5;
   localparam int NUM_FILT = 6;
   localparam int DATA_W   = 16;

   localparam int OUT_W  = IMG_W - K + 1;
   localparam int ROW_W  = $clog2(OUT_W);
   localparam int FILT_W = $clog2(NUM_FILT);
   localparam int ADDR_W = $clog2(NUM_FILT * OUT_W * OUT_W);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Named view of the same encoding, handy when probing the state register.
   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      ISSUE = S_ISSUE,
      WAIT  = S_WAIT,
      WRITE = S_WRITE,
      DONE  = S_DONE
   } sched_state_t;

endpackage

// File: rtl/conv_scheduler_if.sv
// Layer handshake, engine request/response and output-buffer write bundle.
// master = scheduler side, slave = layer control + engine + buffer side.
interface conv_scheduler_if;
   import conv_pkg::*;

   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              err;
   logic              eng_start;
   logic [ROW_W-1:0]  eng_row;
   logic [ROW_W-1:0]  eng_col;
   logic [FILT_W-1:0] eng_filt;
   logic              eng_done;
   logic [DATA_W-1:0] eng_result;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  start, abort, eng_done, eng_result,
      output busy, done, err, eng_start, eng_row, eng_col, eng_filt,
             wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, abort, eng_done, eng_result,
      input  busy, done, err, eng_start, eng_row, eng_col, eng_filt,
             wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/conv_index_counter.sv
// Nested col/row/filt output-pixel counters with a flat address that simply
// increments alongside them, so no multiplier is needed for the buffer address.
module conv_index_counter
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_advance,
   output logic [FILT_W-1:0] o_filt,
   output logic [ROW_W-1:0]  o_row,
   output logic [ROW_W-1:0]  o_col,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   localparam logic [ROW_W-1:0]  POS_MAX  = ROW_W'(OUT_W - 1);
   localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(NUM_FILT - 1);

   logic [FILT_W-1:0] r_filt;
   logic [ROW_W-1:0]  r_row;
   logic [ROW_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_addr;
   logic              w_col_wrap;
   logic              w_row_wrap;

   assign w_col_wrap = (r_col == POS_MAX);
   assign w_row_wrap = (r_row == POS_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_addr <= '0;
      end else if (i_clear) begin
         r_filt <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_addr <= '0;
      end else if (i_advance) begin
         r_addr <= r_addr + 1'b1;
         if (w_col_wrap) begin
            r_col <= '0;
            if (w_row_wrap) begin
               r_row  <= '0;
               r_filt <= r_filt + 1'b1;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_filt = r_filt;
   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_addr = r_addr;
   assign o_last = (r_filt == FILT_MAX) && w_row_wrap && w_col_wrap;

endmodule

// File: rtl/conv_scheduler.sv
// Walks one shared window MAC engine over every (filter,row,col) output pixel,
// one request in flight at a time, and writes each result to the flat buffer.
module conv_scheduler
   import conv_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   conv_scheduler_if.master bus
);

   localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_err;
   logic [DATA_W-1:0] r_wdata;

   logic              w_clear;
   logic              w_adv;
   logic              w_cap;
   logic              w_tmo;
   logic              w_last;
   logic [FILT_W-1:0] w_filt;
   logic [ROW_W-1:0]  w_row;
   logic [ROW_W-1:0]  w_col;
   logic [ADDR_W-1:0] w_addr;

   conv_index_counter u_idx (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_advance (w_adv),
      .o_filt    (w_filt),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_addr    (w_addr),
      .o_last    (w_last)
   );

   // abort outranks engine completion and timeout in every active state.
   assign w_clear = (r_state == S_IDLE)  && bus.start;
   assign w_cap   = (r_state == S_WAIT)  && !bus.abort && bus.eng_done;
   assign w_tmo   = (r_state == S_WAIT)  && !bus.abort && !bus.eng_done && (r_tmo == TMO_LAST);
   assign w_adv   = (r_state == S_WRITE) && !bus.abort && !w_last;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_ISSUE;
         S_ISSUE: w_next = bus.abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (bus.abort || w_tmo) w_next = S_IDLE;
            else if (bus.eng_done)  w_next = S_WRITE;
         end
         S_WRITE: begin
            if (bus.abort)   w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
            else             w_next = S_ISSUE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
         r_err   <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_ISSUE)     r_tmo <= '0;
         else if (r_state == S_WAIT) r_tmo <= r_tmo + 1'b1;
         if (w_clear)    r_err <= 1'b0;
         else if (w_tmo) r_err <= 1'b1;
         if (w_cap) r_wdata <= bus.eng_result;
      end
   end

   // Strobes decode straight from the state register; indices stay put from
   // ISSUE through WRITE because the counter only moves on leaving WRITE.
   assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.err       = r_err;
   assign bus.eng_start = (r_state == S_ISSUE);
   assign bus.eng_filt  = w_filt;
   assign bus.eng_row   = w_row;
   assign bus.eng_col   = w_col;
   assign bus.wr_en     = (r_state == S_WRITE);
   assign bus.wr_addr   = w_addr;
   assign bus.wr_data   = r_wdata;

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: a latency-randomized engine model answers
// window requests, expected buffer writes are queued from index arithmetic.
module tb_conv_scheduler;
   import conv_pkg::*;

   localparam int PLANE = OUT_W * OUT_W;
   localparam int NOUT  = NUM_FILT * PLANE;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic clk_en = 1'b1;

   always #5 clk = clk_en ? ~clk : 1'b0;

   conv_scheduler_if bus ();

   conv_scheduler #(.TIMEOUT(64)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   int   start_cnt = 0;
   int   lat_min = 3;
   int   lat_max = 3;
   bit   eng_silent = 0;
   bit   inject_spur = 0;
   logic [2:0] salt = 3'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] enc(input logic [2:0] s, input int f, input int r, input int c);
      logic [2:0] ff;
      logic [4:0] rr;
      logic [4:0] cc;
      ff = 3'(f);
      rr = 5'(r);
      cc = 5'(c);
      return {s, ff, rr, cc};
   endfunction

   // Expected writes for the first n outputs of a pass, in col/row/filt order.
   task automatic push_pass(input int n);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         e.addr = ADDR_W'(i);
         e.data = enc(salt, i / PLANE, (i / OUT_W) % OUT_W, i % OUT_W);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   end

   // Engine model: answers each request lat cycles after eng_start.
   initial begin
      bit pend;
      int cnt;
      logic [DATA_W-1:0] res;
      pend = 0;
      cnt  = 0;
      res  = '0;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;
      forever begin
         @(negedge clk);
         bus.eng_done   = 1'b0;
         bus.eng_result = DATA_W'($urandom);
         if (!rst_n) begin
            pend = 0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  bus.eng_done   = 1'b1;
                  bus.eng_result = res;
                  pend = 0;
               end
            end
            if (bus.eng_start) begin
               start_cnt++;
               if (!eng_silent) begin
                  pend = 1;
                  cnt  = $urandom_range(lat_max, lat_min);
                  res  = enc(salt, int'(bus.eng_filt), int'(bus.eng_row), int'(bus.eng_col));
               end
            end
            if (bus.wr_en && inject_spur && !pend) begin
               bus.eng_done   = 1'b1;
               bus.eng_result = 16'hDEAD;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every buffer write.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.done) begin
               done_cnt++;
               chk("done_err_excl", 32'(bus.err), 32'd0);
            end
            if (bus.wr_en) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL wr_unexpected: got addr %0d expected no write", bus.wr_addr);
               end else begin
                  wr_t e;
                  int  a;
                  e = exp_q.pop_front();
                  a = int'(e.addr);
                  chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                  chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                  chk("eng_idx", 32'({bus.eng_filt, bus.eng_row, bus.eng_col}),
                      32'(((a / PLANE) << 10) | (((a / OUT_W) % OUT_W) << 5) | (a % OUT_W)));
               end
            end
         end
      end
   end

   initial begin
      int  c0;
      int  dcyc;
      int  s0;
      int  b;
      bit  seen;
      bus.start = 1'b0;
      bus.abort = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.done),      32'd0);
      chk("rst_err",   32'(bus.err),       32'd0);
      chk("rst_estart",32'(bus.eng_start), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en),     32'd0);
      chk("rst_waddr", 32'(bus.wr_addr),   32'd0);
      chk("rst_wdata", 32'(bus.wr_data),   32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // full pass, fixed latency 3, cycle-exact done
      salt = 3'($urandom);
      lat_min = 3; lat_max = 3;
      push_pass(NOUT);
      wr_cnt = 0; done_cnt = 0;
      c0 = cyc;
      pulse_start();
      chk("p1_busy", 32'(bus.busy), 32'd1);
      seen = 0; dcyc = 0;
      for (b = 0; b < 30000; b++) begin
         if (bus.done) begin seen = 1; dcyc = cyc; break; end
         @(negedge clk);
      end
      chk("p1_done_seen", 32'(seen), 32'd1);
      chk("p1_done_cycle", 32'(dcyc - c0), 32'd23521);
      chk("p1_busy_at_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("p1_wr_count", 32'(wr_cnt), 32'(NOUT));
      chk("p1_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("p1_done_pulse", 32'(bus.done), 32'd0);
      chk("p1_err", 32'(bus.err), 32'd0);

      // timeout: engine never answers
      eng_silent = 1;
      wr_cnt = 0; done_cnt = 0;
      c0 = cyc;
      pulse_start();
      seen = 0; dcyc = 0;
      for (b = 0; b < 200; b++) begin
         if (!bus.busy) begin seen = 1; dcyc = cyc; break; end
         @(negedge clk);
      end
      chk("to_idle_seen", 32'(seen), 32'd1);
      chk("to_cycle", 32'(dcyc - c0), 32'd66);
      chk("to_err", 32'(bus.err), 32'd1);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", 32'(bus.err), 32'd1);
      chk("to_no_write", 32'(wr_cnt), 32'd0);
      chk("to_no_done", 32'(done_cnt), 32'd0);
      eng_silent = 0;

      // abort in WAIT of output 100; new start clears err
      salt = 3'($urandom);
      push_pass(100);
      wr_cnt = 0;
      pulse_start();
      chk("ab_err_cleared", 32'(bus.err), 32'd0);
      for (b = 0; b < 2000 && wr_cnt < 100; b++) @(negedge clk);
      for (b = 0; b < 20 && !bus.eng_start; b++) @(negedge clk);
      chk("ab_reached_100", 32'(wr_cnt), 32'd100);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("ab_busy", 32'(bus.busy), 32'd0);
      s0 = start_cnt;
      repeat (20) @(negedge clk);
      chk("ab_no_estart", 32'(start_cnt), 32'(s0));
      chk("ab_no_write", 32'(wr_cnt), 32'd100);
      chk("ab_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("ab_no_done", 32'(done_cnt), 32'd0);
      chk("ab_err_kept", 32'(bus.err), 32'd0);

      // restart from addr 0, random latency, spurious eng_done, starts while busy
      salt = 3'($urandom);
      lat_min = 1; lat_max = 3;
      inject_spur = 1;
      push_pass(NOUT);
      wr_cnt = 0; done_cnt = 0;
      pulse_start();
      seen = 0;
      for (b = 0; b < 40000; b++) begin
         if (bus.done) begin seen = 1; bus.start = 1'b0; break; end
         bus.start = ($urandom_range(31, 0) == 0);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("p3_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      chk("p3_wr_count", 32'(wr_cnt), 32'(NOUT));
      chk("p3_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("p3_done_count", 32'(done_cnt), 32'd1);
      repeat (3) @(negedge clk);
      chk("p3_idle", 32'(bus.busy), 32'd0);
      inject_spur = 0;

      // async reset mid-WAIT with the clock stopped
      lat_min = 3; lat_max = 3;
      eng_silent = 1;
      pulse_start();
      for (b = 0; b < 10 && !bus.eng_start; b++) @(negedge clk);
      @(negedge clk);
      chk("ar_in_wait", 32'(bus.busy), 32'd1);
      clk_en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("ar_busy",   32'(bus.busy),      32'd0);
      chk("ar_estart", 32'(bus.eng_start), 32'd0);
      chk("ar_wr_en",  32'(bus.wr_en),     32'd0);
      chk("ar_done",   32'(bus.done),      32'd0);
      chk("ar_err",    32'(bus.err),       32'd0);
      chk("ar_waddr",  32'(bus.wr_addr),   32'd0);
      chk("ar_wdata",  32'(bus.wr_data),   32'd0);
      #5 rst_n = 1'b1;
      eng_silent = 0;
      clk_en = 1'b1;
      @(negedge clk);
      s0 = start_cnt;
      repeat (10) @(negedge clk);
      chk("ar_stay_idle", 32'(bus.busy), 32'd0);
      chk("ar_no_estart", 32'(start_cnt), 32'(s0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
